// File: rtl/fp51_alu_pkg.sv
// Shared types for the fp51 ALU adder/subtractor slice: operation codes,
// FSM states and the small decode helpers used by add_subb_unit.
package fp51_alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_ADDC = 2'd1,
      ALU_SUBB = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int DATA_W   = 8;
   localparam int NIBBLE_W = 4;

   // The reserved code 2'b11 matches neither ADDC nor SUBB, so it decodes as ADD.
   function automatic logic is_subb(input alu_op_e o);
      return (o == ALU_SUBB);
   endfunction

   function automatic logic nibble_cin(input alu_op_e o, input logic cy);
      logic c;
      case (o)
         ALU_ADDC: c = cy;
         ALU_SUBB: c = ~cy;
         default:  c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple adder exposing both the carry out of bit 3 and the carry out of
// bit 2, so the upper step can derive signed overflow (c7 ^ c8).
module nibble_adder
   import fp51_alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout,
   output logic                c3
);

   logic [3:0] low3;
   logic [1:0] top;

   always_comb begin
      low3 = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
      top  = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low3[3]};
      sum  = {top[0], low3[2:0]};
      cout = top[1];
      c3   = low3[3];
   end

endmodule

// File: rtl/add_subb_unit.sv
// Two-step 8-bit ADD/ADDC/SUBB unit: the low nibble is added on the accept edge,
// the high nibble and all flags on the following edge, then a one-cycle done.
module add_subb_unit
   import fp51_alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_in,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] ACC,
   input  logic [DATA_W-1:0] operand,
   input  logic              CY,
   output logic              busy,
   output logic              done_out,
   output logic [DATA_W-1:0] sum,
   output logic              c_flag,
   output logic              ac_flag,
   output logic              ov_flag
);

   state_e                state;
   alu_op_e               op_r;
   logic [NIBBLE_W-1:0]   acc_hi;
   logic [NIBBLE_W-1:0]   opb_hi;
   logic [NIBBLE_W-1:0]   low_sum;
   logic                  c4_r;

   alu_op_e               op_in;
   logic [NIBBLE_W-1:0]   nib_a;
   logic [NIBBLE_W-1:0]   nib_b;
   logic                  nib_cin;
   logic [NIBBLE_W-1:0]   nib_sum;
   logic                  nib_cout;
   logic                  nib_c3;

   // One adder serves both steps: live low nibbles when accepting, latched high
   // nibbles plus the stored low carry while in S_HIGH.
   always_comb begin
      op_in   = alu_op_e'(op);
      nib_a   = ACC[3:0];
      nib_b   = is_subb(op_in) ? ~operand[3:0] : operand[3:0];
      nib_cin = nibble_cin(op_in, CY);
      if (state == S_HIGH) begin
         nib_a   = acc_hi;
         nib_b   = is_subb(op_r) ? ~opb_hi : opb_hi;
         nib_cin = c4_r;
      end
   end

   nibble_adder u_nibble_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (nib_cin),
      .sum  (nib_sum),
      .cout (nib_cout),
      .c3   (nib_c3)
   );

   // Results move only on the S_HIGH -> S_DONE edge; SUBB reports borrows as
   // inverted carries.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         op_r     <= ALU_ADD;
         acc_hi   <= '0;
         opb_hi   <= '0;
         low_sum  <= '0;
         c4_r     <= 1'b0;
         busy     <= 1'b0;
         done_out <= 1'b0;
         sum      <= '0;
         c_flag   <= 1'b0;
         ac_flag  <= 1'b0;
         ov_flag  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done_out <= 1'b0;
               if (enable_in) begin
                  op_r    <= op_in;
                  acc_hi  <= ACC[7:4];
                  opb_hi  <= operand[7:4];
                  low_sum <= nib_sum;
                  c4_r    <= nib_cout;
                  busy    <= 1'b1;
                  state   <= S_HIGH;
               end else begin
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_HIGH: begin
               sum      <= {nib_sum, low_sum};
               c_flag   <= is_subb(op_r) ? ~nib_cout : nib_cout;
               ac_flag  <= is_subb(op_r) ? ~c4_r : c4_r;
               ov_flag  <= nib_c3 ^ nib_cout;
               busy     <= 1'b0;
               done_out <= 1'b1;
               state    <= S_DONE;
            end
            default: begin
               busy     <= 1'b0;
               done_out <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_subb_unit.sv
// Directed self-checking bench for add_subb_unit: hand-computed vectors,
// throughput with enable held high, and reset abort during S_HIGH.
module tb_add_subb_unit;

   logic       clk;
   logic       reset_n;
   logic       enable_in;
   logic [1:0] op;
   logic [7:0] ACC;
   logic [7:0] operand;
   logic       CY;
   logic       busy;
   logic       done_out;
   logic [7:0] sum;
   logic       c_flag;
   logic       ac_flag;
   logic       ov_flag;

   int assert_count;
   int fail_count;
   int done_pulses;

   add_subb_unit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable_in (enable_in),
      .op        (op),
      .ACC       (ACC),
      .operand   (operand),
      .CY        (CY),
      .busy      (busy),
      .done_out  (done_out),
      .sum       (sum),
      .c_flag    (c_flag),
      .ac_flag   (ac_flag),
      .ov_flag   (ov_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      assert_count++;
      assert (obs === expv) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Accept edge, one S_HIGH cycle with scrambled inputs, then sample at S_DONE.
   task automatic apply_stimulus(input string tag, input logic [1:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic cy, input logic [7:0] prev_sum);
      @(negedge clk);
      op = o; ACC = a; operand = b; CY = cy; enable_in = 1'b1;
      @(negedge clk);
      enable_in = 1'b0; op = ~o; ACC = ~a; operand = ~b; CY = ~cy;
      check({tag, " busy"}, {7'd0, busy}, 8'd1);
      check({tag, " done early"}, {7'd0, done_out}, 8'd0);
      check({tag, " sum held"}, sum, prev_sum);
      @(negedge clk);
      check({tag, " done"}, {7'd0, done_out}, 8'd1);
      check({tag, " busy off"}, {7'd0, busy}, 8'd0);
   endtask

   task automatic check_output(input string tag, input logic [7:0] exp_sum, input logic exp_c,
                               input logic exp_ac, input logic exp_ov);
      check({tag, " sum"}, sum, exp_sum);
      check({tag, " c_flag"}, {7'd0, c_flag}, {7'd0, exp_c});
      check({tag, " ac_flag"}, {7'd0, ac_flag}, {7'd0, exp_ac});
      check({tag, " ov_flag"}, {7'd0, ov_flag}, {7'd0, exp_ov});
   endtask

   initial begin
      clk = 1'b0; reset_n = 1'b0; enable_in = 1'b1;
      op = 2'd0; ACC = 8'h55; operand = 8'h33; CY = 1'b1;
      assert_count = 0; fail_count = 0; done_pulses = 0;

      // Reset has priority over a held enable
      repeat (2) @(negedge clk);
      check("reset busy", {7'd0, busy}, 8'd0);
      check("reset done", {7'd0, done_out}, 8'd0);
      check_output("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1; enable_in = 1'b0;

      apply_stimulus("add 38+49", 2'd0, 8'h38, 8'h49, 1'b1, 8'h00);
      check_output("add 38+49", 8'h81, 1'b0, 1'b1, 1'b1);

      apply_stimulus("addc ff+01", 2'd1, 8'hFF, 8'h01, 1'b1, 8'h81);
      check_output("addc ff+01", 8'h01, 1'b1, 1'b1, 1'b0);

      apply_stimulus("add ff+01", 2'd0, 8'hFF, 8'h01, 1'b1, 8'h01);
      check_output("add ff+01", 8'h00, 1'b1, 1'b1, 1'b0);

      apply_stimulus("addc 12+34", 2'd1, 8'h12, 8'h34, 1'b0, 8'h00);
      check_output("addc 12+34", 8'h46, 1'b0, 1'b0, 1'b0);

      apply_stimulus("subb 10-01", 2'd2, 8'h10, 8'h01, 1'b1, 8'h46);
      check_output("subb 10-01", 8'h0E, 1'b0, 1'b1, 1'b0);

      apply_stimulus("subb 80-01", 2'd2, 8'h80, 8'h01, 1'b0, 8'h0E);
      check_output("subb 80-01", 8'h7F, 1'b0, 1'b1, 1'b1);

      apply_stimulus("rsvd 38+49", 2'd3, 8'h38, 8'h49, 1'b1, 8'h7F);
      check_output("rsvd 38+49", 8'h81, 1'b0, 1'b1, 1'b1);

      // Enable held for six edges: accepts on edges 0, 2, 4 only
      for (int k = 0; k < 6; k++) begin
         op = 2'd0; ACC = 8'(8'h10 * k + 1); operand = 8'h01; CY = 1'b1; enable_in = 1'b1;
         @(negedge clk);
         check($sformatf("burst done k=%0d", k), {7'd0, done_out}, {7'd0, (k % 2) == 1});
         if (done_out) begin
            done_pulses++;
            check($sformatf("burst sum k=%0d", k), sum, 8'(8'h10 * (k - 1) + 2));
         end
      end
      enable_in = 1'b0;
      @(negedge clk);
      check("burst idle done", {7'd0, done_out}, 8'd0);
      check("burst idle busy", {7'd0, busy}, 8'd0);
      check("burst pulses", 8'(done_pulses), 8'd3);

      // Reset during S_HIGH aborts with no done pulse
      apply_stimulus("pre-abort", 2'd0, 8'h38, 8'h49, 1'b0, 8'h42);
      check_output("pre-abort", 8'h81, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      op = 2'd2; ACC = 8'h80; operand = 8'h01; CY = 1'b0; enable_in = 1'b1;
      @(negedge clk);
      enable_in = 1'b0;
      check("abort busy", {7'd0, busy}, 8'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort done", {7'd0, done_out}, 8'd0);
      check("abort busy clr", {7'd0, busy}, 8'd0);
      check_output("abort", 8'h00, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("abort no late done", {7'd0, done_out}, 8'd0);

      apply_stimulus("add 01+01", 2'd0, 8'h01, 8'h01, 1'b1, 8'h00);
      check_output("add 01+01", 8'h02, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
